uart_byte_tx: RTL



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_byte_tx_if.sv | 31 +++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_byte_tx.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte transmitter and its baud divider.
// The optional parity stage is enabled by defining UART_PARITY_EN.
package uart_pkg;

   localparam int   UART_DATA_W   = 8;
   localparam logic UART_IDLE_LVL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_DONE   = 3'd5
   } uart_state_t;

   // A divider of 2 still needs one counter bit, so clamp the width at 1.
   function automatic int uart_cnt_w(input int div);
      if (div <= 2) return 1;
      return $clog2(div);
   endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte-level handshake between the send controller (master) and the transmitter (slave).
// Build option UART_PARITY_EN does not change this interface.
interface uart_byte_tx_if;

   // Handshake: send_en is a one-cycle request, accepted only while the transmitter
   // is idle (tx_busy low and no tx_done pulse); data_byte must be valid in that cycle.
   // tx_done pulses once per accepted byte, and the next request is honoured one
   // cycle after it.
   logic                           send_en;
   logic [uart_pkg::UART_DATA_W-1:0] data_byte;
   logic                           uart_tx;
   logic                           tx_done;
   logic                           tx_busy;

   modport master (
      output send_en,
      output data_byte,
      input  uart_tx,
      input  tx_done,
      input  tx_busy
   );

   modport slave (
      input  send_en,
      input  data_byte,
      output uart_tx,
      output tx_done,
      output tx_busy
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..DIV-1 and strobes bit_end on the last count.
// Shared with the receiver; unaffected by UART_PARITY_EN.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic reset_p,
   input  logic clr,
   output logic bit_end
);

   localparam int CNT_W = uart_cnt_w(DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset_p || clr || (cnt_q == CNT_MAX)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bit_end = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter; defining UART_PARITY_EN inserts an even-parity bit
// before the stop bit (8E1). CLK_FREQ/BAUD must be at least 2.
module uart_byte_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600
) (
   input  logic         clk,
   input  logic         reset_p,
   uart_byte_tx_if.slave bus,
   output uart_state_t  state_dbg
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD;
   localparam int IDX_W    = $clog2(UART_DATA_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_W - 1);

   uart_state_t            state_q, state_d;
   logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
   logic [UART_DATA_W-1:0] shift_q, shift_d;
   logic                   tx_q, tx_d;
   logic                   done_q, done_d;
   logic                   busy_q, busy_d;
   logic                   bit_end;
   logic                   cnt_clr;

   // Holding the divider in clear while idle/done aligns the first bit period
   // exactly with the acceptance edge.
   assign cnt_clr = (state_q == ST_IDLE) || (state_q == ST_DONE);

   uart_baud_tick #(
      .DIV (BAUD_DIV)
   ) u_baud_tick (
      .clk     (clk),
      .reset_p (reset_p),
      .clr     (cnt_clr),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk) begin
      if (reset_p) begin
         state_q   <= ST_IDLE;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= UART_IDLE_LVL;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      case (state_q)
         ST_IDLE: begin
            bit_idx_d = '0;
            if (bus.send_en) begin
               shift_d = bus.data_byte;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               bit_idx_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == LAST_IDX) begin
`ifdef UART_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            if (bit_end) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (bit_end) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so the line
   // changes exactly on the clock edge and never glitches.
   always_comb begin
      tx_d   = UART_IDLE_LVL;
      done_d = 1'b0;
      busy_d = 1'b0;
      case (state_d)
         ST_START: begin
            tx_d   = 1'b0;
            busy_d = 1'b1;
         end
         ST_DATA: begin
            tx_d   = shift_d[bit_idx_d];
            busy_d = 1'b1;
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            tx_d   = ^shift_d;
            busy_d = 1'b1;
         end
`endif
         ST_STOP: begin
            busy_d = 1'b1;
         end
         ST_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            tx_d = UART_IDLE_LVL;
         end
      endcase
   end

   assign bus.uart_tx = tx_q;
   assign bus.tx_done = done_q;
   assign bus.tx_busy = busy_q;
   assign state_dbg   = state_q;

endmodule
